// File: rtl/fmeas_frame_tx.sv
// fmeas_frame_tx: snapshots NUM_CH counters and streams framed Manchester data.
// Optional CRC-8 trailer is enabled by defining FMEAS_FRAME_CRC_EN.
module fmeas_frame_tx #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 20,
  parameter  int SYNC_STAGES = 3,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    latch_req,
  input  logic                    scan_mode,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [NUM_CH*CNT_W-1:0] cnt_bus,
  output logic                    tx_bit,
  output logic                    tx_mc,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

`ifdef FMEAS_FRAME_CRC_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif
  localparam int FRAME_LEN = 8 + CNT_W + CRC_W;
  localparam int BC_W = $clog2(FRAME_LEN);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, NEXT} state_t;

  state_t                  r_state, w_nxt;
  logic [SYNC_STAGES-1:0]  r_sync, r_svld;
  logic                    r_prev, r_pvld, w_trig;
  logic [NUM_CH*CNT_W-1:0] r_snap, w_src;
  logic [FRAME_LEN-1:0]    r_sr, w_frame;
  logic [BC_W-1:0]         r_bcnt;
  logic [3:0]              r_ch, w_ld_id;
  logic [CNT_W-1:0]        w_ld_cnt;
  logic                    r_scan, r_tx, r_done, r_ovr;
  logic                    w_first, w_load, w_shift;
  logic                    w_done, w_ovr;

  // r_svld marks real samples so a level held across reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_svld <= '0;
      r_prev <= 1'b0;
      r_pvld <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], latch_req};
      r_svld <= {r_svld[SYNC_STAGES-2:0], 1'b1};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_pvld <= r_svld[SYNC_STAGES-1];
    end
  end

  assign w_trig = r_pvld & r_sync[SYNC_STAGES-1] & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_first = 1'b0;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    if (!ena) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_trig) begin
            w_nxt   = SHIFT;
            w_first = 1'b1;
            w_load  = 1'b1;
          end
        end
        SHIFT: begin
          w_shift = 1'b1;
          if (r_bcnt == '0) begin
            w_done = 1'b1;
            w_nxt  = (r_scan && r_ch != LAST_CH) ? NEXT : IDLE;
          end
        end
        NEXT: begin
          w_nxt  = SHIFT;
          w_load = 1'b1;
        end
        default: w_nxt = IDLE;
      endcase
    end
    w_ovr = w_trig && (r_state != IDLE);
  end

  always_comb begin
    w_ld_id  = r_ch + 4'd1;
    w_src    = r_snap;
    w_ld_cnt = '0;
    if (w_first) begin
      w_ld_id = scan_mode ? 4'd0 : 4'(ch_sel);
      w_src   = cnt_bus;
    end
    for (int k = 0; k < NUM_CH; k++)
      if (w_ld_id == 4'(k)) w_ld_cnt = w_src[k*CNT_W +: CNT_W];
  end

`ifdef FMEAS_FRAME_CRC_EN
  function automatic logic [7:0] crc8(input logic [CNT_W+3:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = CNT_W + 3; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  assign w_frame = {4'b1010, w_ld_id, w_ld_cnt,
                    crc8({w_ld_id, w_ld_cnt})};
`else
  assign w_frame = {4'b1010, w_ld_id, w_ld_cnt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
      r_sr   <= '0;
      r_bcnt <= '0;
      r_ch   <= '0;
      r_scan <= 1'b0;
      r_tx   <= 1'b0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_done;
      r_ovr  <= w_ovr;
      if (w_first) begin
        r_snap <= cnt_bus;
        r_scan <= scan_mode;
      end
      if (!ena) begin
        r_tx <= 1'b0;
      end else if (w_load) begin
        r_tx   <= w_frame[FRAME_LEN-1];
        r_sr   <= w_frame << 1;
        r_bcnt <= BC_W'(FRAME_LEN - 1);
        r_ch   <= w_ld_id;
      end else if (w_shift) begin
        r_tx   <= (r_bcnt == '0) ? 1'b0 : r_sr[FRAME_LEN-1];
        r_sr   <= r_sr << 1;
        r_bcnt <= r_bcnt - 1'b1;
      end
    end
  end

  assign tx_bit     = r_tx;
  assign tx_mc      = r_tx ^ clk;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;
  assign overrun    = r_ovr;

endmodule
